// File: rtl/pwm_led_array.sv
// pwm_led_array: CH-channel LED PWM with key-adjusted duty/frequency and one shared sequential divider.
// Define PWM_PHASE_STAGGER_EN to spread the reset counter phases across channels.
module pwm_led_array #(
    parameter int CH        = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int DUTY_MAX  = 99,
    parameter int DUTY_STEP = 2,
    parameter int FREQ_MAX  = 200,
    parameter int FREQ_MIN  = 4,
    parameter int FREQ_STEP = 4,
    parameter int PW        = 24,
    parameter int DIV_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_key,
    input  logic                  duty_key,
    input  logic                  freq_key,
    output logic [CH-1:0]         led,
    output logic [$clog2(CH)-1:0] cur_ch,
    output logic [6:0]            cur_duty,
    output logic [7:0]            cur_freq,
    output logic                  busy
);
    localparam int CW = $clog2(CH);
    localparam int IW = $clog2(DIV_W);
    localparam longint P0L = longint'(CLK_HZ) / FREQ_MAX;
    localparam logic [PW-1:0] P0 = PW'(P0L);
    localparam logic [PW-1:0] H0 = PW'(P0L * DUTY_MAX / 100);

    typedef enum logic [1:0] {IDLE, DIV_P, DIV_H, STORE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         it_q, it_d;
    logic [DIV_W-1:0]      num_q, num_d, den_q, den_d, rem_q, rem_d, num_nx;
    logic [DIV_W:0]        rem_sh;
    logic                  ge, last;
    logic [CW-1:0]         ch_q, ch_d, cur_ch_q, cur_ch_d, pick;
    logic [6:0]            dl_q, dl_d;
    logic [PW-1:0]         pn_q, pn_d;
    logic [CH-1:0]         pending_q, pending_d, upd_q, upd_d, led_q, led_d, wrap;
    logic [CH-1:0][6:0]    duty_q, duty_d;
    logic [CH-1:0][7:0]    freq_q, freq_d;
    logic [CH-1:0][PW-1:0] shadow_p_q, shadow_p_d, shadow_h_q, shadow_h_d;
    logic [CH-1:0][PW-1:0] period_q, period_d, high_q, high_d, cnt_q, cnt_d;

    // num_q holds the shifting dividend and collects quotient bits from the bottom
    always_comb begin
        rem_sh = {rem_q, num_q[DIV_W-1]};
        ge     = rem_sh >= {1'b0, den_q};
        num_nx = {num_q[DIV_W-2:0], ge};
        last   = it_q == IW'(DIV_W - 1);
        pick   = '0;
        for (int i = CH - 1; i >= 0; i--) if (pending_q[i]) pick = CW'(i);
    end

    always_comb begin
        state_d    = state_q;
        it_d       = it_q + 1'b1;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        ch_d       = ch_q;
        dl_d       = dl_q;
        pn_d       = pn_q;
        pending_d  = pending_q;
        shadow_p_d = shadow_p_q;
        shadow_h_d = shadow_h_q;
        upd_d      = upd_q;
        duty_d     = duty_q;
        freq_d     = freq_q;
        wrap       = '0;
        cnt_d      = cnt_q;
        period_d   = period_q;
        high_d     = high_q;
        led_d      = '0;
        for (int i = 0; i < CH; i++) begin
            wrap[i]     = cnt_q[i] == period_q[i] - 1'b1;
            cnt_d[i]    = wrap[i] ? '0 : cnt_q[i] + 1'b1;
            period_d[i] = wrap[i] && upd_q[i] ? shadow_p_q[i] : period_q[i];
            high_d[i]   = wrap[i] && upd_q[i] ? shadow_h_q[i] : high_q[i];
            upd_d[i]    = upd_q[i] && !wrap[i];
            led_d[i]    = cnt_q[i] < high_q[i];
        end
        case (state_q)
            IDLE: if (|pending_q) begin
                pending_d[pick] = 1'b0;
                ch_d            = pick;
                dl_d            = duty_q[pick];
                num_d           = DIV_W'(CLK_HZ);
                den_d           = DIV_W'(freq_q[pick]);
                rem_d           = '0;
                it_d            = '0;
                state_d         = DIV_P;
            end
            DIV_P, DIV_H: begin
                num_d = num_nx;
                rem_d = ge ? DIV_W'(rem_sh - {1'b0, den_q}) : rem_sh[DIV_W-1:0];
                if (last) begin
                    it_d    = '0;
                    state_d = state_q == DIV_P ? DIV_H : STORE;
                    if (state_q == DIV_P) begin
                        pn_d  = num_nx[PW-1:0];
                        num_d = DIV_W'(num_nx[PW-1:0]) * DIV_W'(dl_q);
                        den_d = DIV_W'(100);
                        rem_d = '0;
                    end
                end
            end
            default: begin
                // a store on a wrap edge sets upd after the wrap clears it, so it loads next wrap
                shadow_p_d[ch_q] = pn_q;
                shadow_h_d[ch_q] = num_q[PW-1:0];
                upd_d[ch_q]      = 1'b1;
                state_d          = IDLE;
            end
        endcase
        if (duty_key) duty_d[cur_ch_q] = duty_q[cur_ch_q] <= 7'(DUTY_STEP) ? 7'(DUTY_MAX) : duty_q[cur_ch_q] - 7'(DUTY_STEP);
        if (freq_key) freq_d[cur_ch_q] = freq_q[cur_ch_q] < 8'(FREQ_MIN + FREQ_STEP) ? 8'(FREQ_MAX) : freq_q[cur_ch_q] - 8'(FREQ_STEP);
        if (duty_key || freq_key) pending_d[cur_ch_q] = 1'b1;
        cur_ch_d = sel_key ? (cur_ch_q == CW'(CH - 1) ? '0 : cur_ch_q + 1'b1) : cur_ch_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            it_q      <= '0;
            num_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            ch_q      <= '0;
            dl_q      <= '0;
            pn_q      <= '0;
            pending_q <= '0;
            upd_q     <= '0;
            led_q     <= '0;
            cur_ch_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                duty_q[i]     <= 7'(DUTY_MAX);
                freq_q[i]     <= 8'(FREQ_MAX);
                shadow_p_q[i] <= P0;
                shadow_h_q[i] <= H0;
                period_q[i]   <= P0;
                high_q[i]     <= H0;
`ifdef PWM_PHASE_STAGGER_EN
                cnt_q[i]      <= PW'(longint'(i) * (P0L / CH));
`else
                cnt_q[i]      <= '0;
`endif
            end
        end else begin
            state_q    <= state_d;
            it_q       <= it_d;
            num_q      <= num_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            ch_q       <= ch_d;
            dl_q       <= dl_d;
            pn_q       <= pn_d;
            pending_q  <= pending_d;
            upd_q      <= upd_d;
            led_q      <= led_d;
            cur_ch_q   <= cur_ch_d;
            duty_q     <= duty_d;
            freq_q     <= freq_d;
            shadow_p_q <= shadow_p_d;
            shadow_h_q <= shadow_h_d;
            period_q   <= period_d;
            high_q     <= high_d;
            cnt_q      <= cnt_d;
        end
    end

    assign led      = led_q;
    assign cur_ch   = cur_ch_q;
    assign cur_duty = duty_q[cur_ch_q];
    assign cur_freq = freq_q[cur_ch_q];
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_pwm_led_array.sv
// tb_pwm_led_array: directed scoreboard bench for pwm_led_array at CLK_HZ=10000, CH=4.
module tb_pwm_led_array;
    logic       clk = 1'b0, rst = 1'b1, sel_key = 1'b0, duty_key = 1'b0, freq_key = 1'b0;
    logic [3:0] led;
    logic [1:0] cur_ch;
    logic [6:0] cur_duty;
    logic [7:0] cur_freq;
    logic       busy;

    typedef struct {string tag; integer exp;} exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    pwm_led_array #(.CH(4), .CLK_HZ(10000)) dut (
        .clk(clk), .rst(rst), .sel_key(sel_key), .duty_key(duty_key), .freq_key(freq_key),
        .led(led), .cur_ch(cur_ch), .cur_duty(cur_duty), .cur_freq(cur_freq), .busy(busy)
    );

    task automatic push(input string tag, input integer exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check(input integer obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0d expected none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic press(input logic s, input logic d, input logic f);
        sel_key = s; duty_key = d; freq_key = f;
        @(negedge clk);
        sel_key = 1'b0; duty_key = 1'b0; freq_key = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 400);
    endtask

    // Measures one period starting at a rising edge of led[ch]; chained means we already sit on a rise
    task automatic measure(input int ch, input bit chained, output int hi, output int per);
        logic p;
        bit   ok;
        hi = -1; per = -1; ok = chained;
        p = led[ch];
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = led[ch] && !p;
            p  = led[ch];
        end
        if (!ok) return;
        hi = 0; per = 0;
        for (int n = 0; n < 300; n++) begin
            p = led[ch];
            if (p) hi++;
            @(negedge clk);
            per++;
            if (led[ch] && !p) break;
        end
    endtask

    task automatic chk_pulse(input int ch, input int eh, input int ep);
        int hi, per;
        measure(ch, 1'b0, hi, per);
        push($sformatf("ch%0d_high", ch), eh);   check(hi);
        push($sformatf("ch%0d_period", ch), ep); check(per);
    endtask

    initial begin
        int n, hi, per, d, f, last_busy;
        logic b1, b66;
        repeat (3) @(negedge clk);
        push("rst_led", 0);        check(led);
        push("rst_busy", 0);       check(busy);
        push("rst_cur_ch", 0);     check(cur_ch);
        push("rst_cur_duty", 99);  check(cur_duty);
        push("rst_cur_freq", 200); check(cur_freq);
        rst = 1'b0;
        @(negedge clk);
        push("phase_e1", 15) ; check(led);
        repeat (49) @(negedge clk);
        push("phase_e50", 0);  check(led);
        @(negedge clk);
        push("phase_e51", 15); check(led);
        for (int c = 0; c < 4; c++) chk_pulse(c, 49, 50);

        // single duty press on ch0
        push("duty_ch0", 97);
        press(1'b0, 1'b1, 1'b0);
        check(cur_duty);
        push("busy_len_1ch", 66);
        wait_idle(n);
        check(n);
        repeat (60) @(negedge clk);
        chk_pulse(0, 48, 50);
        chk_pulse(1, 49, 50);

        // freq press on ch0: every pulse is either fully old or fully new
        do_reset();
        push("freq_ch0", 196);
        press(1'b0, 1'b0, 1'b1);
        check(cur_freq);
        measure(0, 1'b0, hi, per);
        for (int k = 0; k < 6; k++) begin
            push("freq_no_trunc", 1);
            check(int'((hi == 49 && per == 50) || (hi == 50 && per == 51)));
            if (k < 5) measure(0, 1'b1, hi, per);
        end
        push("freq_new_high", 50);   check(hi);
        push("freq_new_period", 51); check(per);

        // duty and frequency sweeps through their wraps
        do_reset();
        d = 99; f = 200;
        for (int k = 0; k < 50; k++) begin
            d = (d <= 2) ? 99 : d - 2;
            push($sformatf("duty_sweep%0d", k), d);
            press(1'b0, 1'b1, 1'b0);
            check(cur_duty);
        end
        for (int k = 0; k < 50; k++) begin
            f = (f - 4 < 4) ? 200 : f - 4;
            push($sformatf("freq_sweep%0d", k), f);
            press(1'b0, 1'b0, 1'b1);
            check(cur_freq);
        end
        d = (d <= 2) ? 99 : d - 2;
        f = (f - 4 < 4) ? 200 : f - 4;
        push("both_duty", d); push("both_freq", f);
        press(1'b0, 1'b1, 1'b1);
        check(cur_duty); check(cur_freq);

        // channel select wrap, then select together with an adjustment
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("sel%0d", k), k % 4);
            press(1'b1, 1'b0, 1'b0);
            check(cur_ch);
        end
        d = (d <= 2) ? 99 : d - 2;
        push("sel_adj_ch", 1); push("sel_adj_ch1_duty", 99);
        press(1'b1, 1'b1, 1'b0);
        check(cur_ch); check(cur_duty);
        repeat (3) press(1'b1, 1'b0, 1'b0);
        push("sel_adj_ch0_duty", d);
        check(cur_duty);

        // two channels pressed on consecutive edges share the divider
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        push("two_ch_sel", 2); push("two_ch_ch2_duty", 99);
        press(1'b1, 1'b1, 1'b0);
        check(cur_ch); check(cur_duty);
        push("two_ch_ch2_pressed", 97);
        press(1'b0, 1'b1, 1'b0);
        check(cur_duty);
        b1 = busy; b66 = 1'bx; last_busy = 0;
        for (n = 2; n <= 200; n++) begin
            @(negedge clk);
            if (n == 66) b66 = busy;
            if (busy) last_busy = n;
        end
        push("two_ch_busy_start", 1); check(b1);
        push("two_ch_idle_gap", 0);   check(b66);
        push("two_ch_busy_end", 132); check(last_busy + 1);
        chk_pulse(1, 48, 50);
        chk_pulse(2, 48, 50);
        chk_pulse(3, 49, 50);

        // reset in the middle of DIV_H discards all pending work
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        push("mid_busy", 1); check(busy);
        rst = 1'b1;
        @(negedge clk);
        push("mid_rst_busy", 0);  check(busy);
        push("mid_rst_duty", 99); check(cur_duty);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push("mid_rst_no_recompute", 0); check(busy);
        repeat (120) @(negedge clk);
        chk_pulse(0, 49, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pwm_led_array.md
Name: pwm_led_array

Overview:
- Multi-channel successor to the single-LED FM/PWM controller.
- Drives CH LEDs, each with its own key-adjusted duty (percent) and frequency (Hz).
- A shared sequential divider converts settings to tick counts, and new values take effect glitch-free at each channel's period boundary.
- Sits between the key_filter press pulses and the LEDs; the selected channel's duty and frequency are exported for seg_module.

Parameters:
CH, 4, number of LED channels (2..8)
CLK_HZ, 50_000_000, clk frequency in Hz
DUTY_MAX, 99, duty reset/wrap value in percent
DUTY_STEP, 2, duty decrement per press
FREQ_MAX, 200, frequency reset/wrap value in Hz
FREQ_MIN, 4, lowest legal frequency
FREQ_STEP, 4, frequency decrement per press
PW, 24, period/high counter width
DIV_W, 32, divider operand width and iteration count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sel_key  in  1  one-cycle press pulse; advances the selected channel
duty_key  in  1  one-cycle pulse; decrements the selected channel's duty
freq_key  in  1  one-cycle pulse; decrements the selected channel's frequency
led  out  CH  registered PWM outputs, bit i is channel i
cur_ch  out  $clog2(CH)  selected channel
cur_duty  out  7  duty of the selected channel
cur_freq  out  8  frequency of the selected channel
busy  out  1  divider FSM not in IDLE

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset state:
  - cur_ch=0.
  - All duty=DUTY_MAX, all freq=FREQ_MAX.
  - Active period = P0 = CLK_HZ/FREQ_MAX; active high = H0 = P0*DUTY_MAX/100. Both are elaboration constants, floor division.
  - All cnt=0; pending, upd, led and busy all 0; FSM in IDLE.
- sel_key: cur_ch <= (cur_ch==CH-1) ? 0 : cur_ch+1.
- duty_key, on channel cur_ch:
  - If duty <= DUTY_STEP, duty <= DUTY_MAX; else duty <= duty-DUTY_STEP.
  - Sets pending[cur_ch].
- freq_key, on channel cur_ch:
  - If freq-FREQ_STEP < FREQ_MIN, freq <= FREQ_MAX; else freq <= freq-FREQ_STEP.
  - Sets pending[cur_ch].
- Simultaneous key pulses:
  - duty_key and freq_key together: both are applied in the same cycle.
  - sel_key together with duty_key/freq_key: the adjustment applies to the old cur_ch, then the selection advances.
- Divider FSM (IDLE, DIV_P, DIV_H, STORE):
  - IDLE: if any pending, pick the lowest-index pending channel c, clear pending[c], latch duty[c] and freq[c], go to DIV_P.
  - DIV_P: radix-2 restoring divide, CLK_HZ/freq, exactly DIV_W cycles. Quotient truncated to PW bits = Pn.
  - DIV_H: (Pn*duty)/100, exactly DIV_W cycles; result = Hn.
  - STORE, one cycle: shadow_p[c]=Pn, shadow_h[c]=Hn, upd[c]=1; return to IDLE.
  - busy=1 in every state except IDLE.
  - upd[c] is written 66 edges after the edge that set pending[c], when the FSM was idle.
- Presses during a computation:
  - A press on the channel being computed sets pending again.
  - The current result is still stored, using the latched values, and a recompute follows.
- Per-channel counter:
  - cnt[i] counts 0..period[i]-1.
  - At cnt==period[i]-1: cnt <= 0, and if upd[i], period[i] <= shadow_p[i], high[i] <= shadow_h[i], upd[i] <= 0.
  - A STORE landing on the wrap edge is loaded at the next wrap, never partially.
- led[i] <= (cnt[i] < high[i]), a one-cycle registered delay.
- Boundaries:
  - high=0 gives a constant 0.
  - high >= period gives a constant 1.
  - Periods are never 0, since freq >= FREQ_MIN.
- cur_duty, cur_freq: combinational mux of the duty/freq registers by cur_ch. They change the cycle after a press, independent of the divider.
- Reset mid-computation: FSM returns to IDLE; all pending, upd and shadows are discarded.

Optional Feature:
- Macro: PWM_PHASE_STAGGER_EN.
- Defined: at reset, cnt[i] = i*(P0/CH), so channel rising edges are spread to limit simultaneous switching current.
- Undefined: all cnt reset to 0, so channels start in phase.
- No other behaviour differs.

Test Plan:
- All tests use CLK_HZ=10000, CH=4.
- Reset: P0=50, H0=49 on all channels. After reset, led toggles high 49 / low 1 per 50 clocks, in phase.
- duty_key on ch0: cur_duty=97; busy for 66 cycles; after the next ch0 wrap, high=48. Channels 1..3 stay unchanged.
- freq_key on ch0: cur_freq=196. The recompute gives period=51, high=50, loaded only at a wrap, with no truncated pulse.
- 50 duty_key presses: duty runs 99,97..1 and the next press returns it to 99. 50 freq_key presses: freq wraps 4 -> 200.
- sel_key x4 wraps cur_ch 3 -> 0. Press ch1 and ch2 within one cycle: ch1 is computed first, ch2 next; busy lasts 132 cycles.
- Assert rst during DIV_H: pending/upd are cleared and all channels return to P0/H0. With PWM_PHASE_STAGGER_EN, the reset counters are 0, 12, 24, 36.
